alu_pipe: RTL
=============

Name: alu_pipe

Overview:
- Parametrised, handshaked successor of the team's fixed 4-bit ALU.
- Same 8-operation set, with generic operand width WIDTH.
- Full-width multiply result; iterative multi-cycle divide/modulo with divide-by-zero reporting.
- Valid/ready handshakes on input and output; the output holds under backpressure.
- Sits between an operand-issuing sequencer and a result consumer in the datapath sample.

Parameters:
- WIDTH, 8, operand width in bits (≥2).
- RW, 2*WIDTH, result width (derived; not overridable).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  block can accept this cycle
- a  in  WIDTH  operand A (unsigned)
- b  in  WIDTH  operand B (unsigned)
- op  in  3  alu_op_e opcode
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  RW  result, zero-extended
- zero  out  1  result == 0
- div_err  out  1  DIV/MOD with b == 0

Behaviour:
- Reset: reset is synchronous, active-low; clock is clk.
  - While reset == 0 at posedge clk: state ← IDLE; out_valid, result, zero, div_err ← 0.
  - Reset mid-division aborts the operation; no output is produced for it.
- Accept: a transfer occurs when in_valid && in_ready.
  - in_ready = (state == IDLE) && (!out_valid || out_ready).
  - Accept and drain in the same cycle are allowed.
- Ops, with results zero-extended to RW:
  - 000 ADD: WIDTH+1-bit sum.
  - 001 SUB: (a − b) mod 2^(WIDTH+1); bit WIDTH = borrow.
  - 010 AND, 011 OR, 101 XOR: bitwise.
  - 100 MUL: full RW-bit product.
  - 110 MOD: remainder.
  - 111 DIV: quotient.
- FSM states: IDLE, DIV, DONE.
  - IDLE + accept of non-DIV/MOD op: result registered and out_valid=1 on the next edge (latency 1). Stay in IDLE.
  - IDLE + accept of DIV/MOD with b ≠ 0: latch a, b, op; go to DIV.
  - DIV: the divider computes one quotient bit per cycle for WIDTH cycles, then → DONE.
  - DONE: result loaded and out_valid=1 on the next edge, → IDLE. Total latency WIDTH+2 cycles from accept.
  - DIV/MOD with b == 0: no iteration, latency 1.
    - DIV → result = all-ones in the low WIDTH bits.
    - MOD → result = a.
    - div_err = 1.
- Output register:
  - result, zero and div_err are stable while out_valid && !out_ready.
  - out_valid clears on handshake unless a new result loads in the same edge.
- zero = (result == 0); div_err = 0 for all ops other than the b == 0 case.
- No x is ever driven on any output.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [2:0] alu_op_e (OP_ADD … OP_DIV, codes as above);
  - typedef enum state_e {IDLE, DIV, DONE}.
- Sub-module alu_divider: restoring, one bit per cycle, parametrised by WIDTH.
  - Interface: start, dividend, divisor, busy, done, quotient, remainder.

Test Plan (WIDTH=4, RW=8):
- ADD a=9, b=8 → out_valid 1 cycle after accept, result=0x11, zero=0.
- SUB a=3, b=5 → result=0x1E (borrow bit 4 set); SUB a=5, b=5 → result=0, zero=1.
- MUL a=15, b=15 → result=225 (0xE1) in 1 cycle.
- DIV a=13, b=4 → result=3 exactly 6 cycles after accept, with in_ready=0 throughout. MOD a=13, b=4 → result=1. DIV a=7, b=0 → result=0x0F, div_err=1 after 1 cycle.
- Backpressure: out_ready=0 for 5 cycles after an ADD → result stays stable, in_ready=0. Then raise out_ready while in_valid carries an XOR → both handshakes occur in the same cycle, and the next result appears 1 cycle later.
- Assert reset=0 for 1 cycle during a DIV at cycle 2 → next edge: out_valid=0, result=0, in_ready=1. No stale result emerges.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state types shared by alu_pipe and its bench.
//   alu_op_e  - 3-bit opcode presented on alu_pipe.op
//   state_e   - alu_pipe control states
//   is_div_op - true for the opcodes that use the iterative divider
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_MUL = 3'b100,
    OP_XOR = 3'b101,
    OP_MOD = 3'b110,
    OP_DIV = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_e;

  function automatic logic is_div_op(input alu_op_e op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_divider.sv
// alu_divider: restoring unsigned divider, one quotient bit per clock.
//   clk, reset      - clock, synchronous active-low reset
//   start           - load dividend/divisor and begin (WIDTH iterations)
//   dividend/divisor- operands, sampled on start
//   busy            - iteration in progress
//   done            - high during the final iteration cycle; quotient and
//                     remainder are final from the following cycle on
//   quotient/remainder - results, held until the next start
module alu_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic [WIDTH-1:0] quo_d, rem_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic [WIDTH:0]   rem_shift, trial;

  // Partial remainder stays below the divisor, so the trial difference fits
  // in WIDTH+1 bits and its top bit is a clean "went negative" flag.
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvs_q};
    if (!trial[WIDTH]) begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = rem_shift[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      quo_q  <= dividend;
      rem_q  <= '0;
      dvs_q  <= divisor;
      cnt_q  <= CW'(WIDTH);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == CW'(1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked WIDTH-bit ALU with registered output and an
// iterative divider for DIV/MOD.
//   clk, reset            - clock, synchronous active-low reset
//   in_valid/in_ready     - operand handshake (a, b, op)
//   out_valid/out_ready   - result handshake; output holds under backpressure
//   result                - RW-bit zero-extended result
//   zero                  - result == 0
//   div_err               - DIV/MOD issued with b == 0
//
// state | meaning
// IDLE  | accepting operands; single-cycle ops complete here
// DIV   | divider iterating, one quotient bit per cycle
// DONE  | divider finished; load quotient/remainder into the output
module alu_pipe
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int RW    = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RW-1:0]    result,
  output logic             zero,
  output logic             div_err
);

  state_e          state_q;
  alu_op_e         op_q;
  logic            out_valid_q, zero_q, div_err_q;
  logic [RW-1:0]   result_q;

  alu_op_e         op_in;
  logic            accept, div_start;
  logic [WIDTH:0]  sum_w, diff_w;
  logic [RW-1:0]   res_fast_d, res_div_d;
  logic            err_fast_d;

  logic             div_busy, div_done;
  logic [WIDTH-1:0] div_quo, div_rem;

  assign op_in     = alu_op_e'(op);
  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign div_start = accept && is_div_op(op_in) && (b != '0);

  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};

  // Single-cycle results. The DIV/MOD entries only matter for b == 0,
  // since a nonzero divisor is routed to the divider instead.
  always_comb begin
    res_fast_d = '0;
    err_fast_d = 1'b0;
    case (op_in)
      OP_ADD: res_fast_d = RW'(sum_w);
      OP_SUB: res_fast_d = RW'(diff_w);
      OP_AND: res_fast_d = RW'(a & b);
      OP_OR:  res_fast_d = RW'(a | b);
      OP_XOR: res_fast_d = RW'(a ^ b);
      OP_MUL: res_fast_d = RW'(a) * RW'(b);
      OP_MOD: begin
        res_fast_d = RW'(a);
        err_fast_d = 1'b1;
      end
      OP_DIV: begin
        res_fast_d = RW'({WIDTH{1'b1}});
        err_fast_d = 1'b1;
      end
    endcase
  end

  assign res_div_d = (op_q == OP_DIV) ? RW'(div_quo) : RW'(div_rem);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      div_err_q   <= 1'b0;
    end else begin
      // A load below overrides this clear when accept and drain coincide.
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (div_start) begin
            op_q    <= op_in;
            state_q <= DIV;
          end else if (accept) begin
            result_q    <= res_fast_d;
            zero_q      <= (res_fast_d == '0);
            div_err_q   <= err_fast_d;
            out_valid_q <= 1'b1;
          end
        end
        DIV: begin
          if (div_busy && div_done) state_q <= DONE;
        end
        DONE: begin
          if (!out_valid_q || out_ready) begin
            result_q    <= res_div_d;
            zero_q      <= (res_div_d == '0);
            div_err_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividend  (a),
    .divisor   (b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign div_err   = div_err_q;

endmodule
